// File: rtl/id_stage_hs_if.sv
// Bundle of IF-side, head-side and EX-side signals of id_stage_hs; slave is the stage's view.
// Defining ID_PERF_CNT_EN adds the two event counter outputs.
interface id_stage_hs_if #(
    parameter int INSTR_WIDTH = 16,
    parameter int ADDR_WIDTH  = 8,
    parameter int REG_WIDTH   = 4,
    parameter int IMM_WIDTH   = 8
);
    logic                   in_valid_i;
    logic                   in_ready_o;
    logic [INSTR_WIDTH-1:0] instr_i;
    logic [ADDR_WIDTH-1:0]  pc_i;
    logic                   flush_i;
    logic [REG_WIDTH-1:0]   rf_r1_o;
    logic [REG_WIDTH-1:0]   rf_r2_o;
    logic                   jump_o;
    logic [IMM_WIDTH-1:0]   jump_addr_o;
    logic                   halted_o;
    logic                   out_valid_o;
    logic                   out_ready_i;
    logic [ADDR_WIDTH-1:0]  pc_o;
    logic [REG_WIDTH-1:0]   rs_o;
    logic [REG_WIDTH-1:0]   rt_o;
    logic [REG_WIDTH-1:0]   rd_o;
    logic [IMM_WIDTH-1:0]   imm_o;
    logic [8:0]             cv_o;
`ifdef ID_PERF_CNT_EN
    logic [15:0]            bubble_cnt_o;
    logic [15:0]            full_cnt_o;
`endif

    modport master (
        output in_valid_i, instr_i, pc_i, flush_i, out_ready_i,
        input  in_ready_o, rf_r1_o, rf_r2_o, jump_o, jump_addr_o, halted_o,
               out_valid_o, pc_o, rs_o, rt_o, rd_o, imm_o, cv_o
`ifdef ID_PERF_CNT_EN
        , input bubble_cnt_o, full_cnt_o
`endif
    );

    modport slave (
        input  in_valid_i, instr_i, pc_i, flush_i, out_ready_i,
        output in_ready_o, rf_r1_o, rf_r2_o, jump_o, jump_addr_o, halted_o,
               out_valid_o, pc_o, rs_o, rt_o, rd_o, imm_o, cv_o
`ifdef ID_PERF_CNT_EN
        , output bubble_cnt_o, full_cnt_o
`endif
    );
endinterface

// File: rtl/id_stage_hs.sv
// Decode stage: BUF_DEPTH FIFO -> CTR decode -> ID/EX register, load-use bubble, sticky halt, flush (ID_PERF_CNT_EN adds counters).
// One edge FIFO-to-ID/EX; out_ready_i low holds ID/EX and FIFO, in_ready_o drops when FIFO full or halted.
module id_stage_hs #(
    parameter int INSTR_WIDTH = 16,
    parameter int ADDR_WIDTH  = 8,
    parameter int OP_WIDTH    = 4,
    parameter int REG_WIDTH   = 4,
    parameter int IMM_WIDTH   = 8,
    parameter int BUF_DEPTH   = 2
) (
    input  logic         clk,
    input  logic         rst,
    id_stage_hs_if.slave bus
);
    localparam int PTR_W = $clog2(BUF_DEPTH);
    localparam int CNT_W = $clog2(BUF_DEPTH + 1);
    localparam int CV_MEMREAD = 5;
    localparam int CV_REGDST  = 4;

    typedef struct packed {
        logic       stop;
        logic       jump;
        logic [8:0] cv;
    } ctr_t;

    // cv bits: RegWrite ALUop Branch MemRead RegDst MemWrite MemToReg Mov Floating
    function automatic ctr_t ctr_decode(input logic [OP_WIDTH-1:0] op);
        ctr_t c;
        c = '0;
        case (op)
            OP_WIDTH'(1):  c.cv = 9'b1_1_0_0_1_0_0_0_0;
            OP_WIDTH'(2):  c.cv = 9'b1_1_0_0_0_0_0_0_0;
            OP_WIDTH'(3):  c.cv = 9'b1_0_0_1_0_0_1_0_0;
            OP_WIDTH'(4):  c.cv = 9'b0_0_0_0_0_1_0_0_0;
            OP_WIDTH'(5):  c.cv = 9'b0_1_1_0_0_0_0_0_0;
            OP_WIDTH'(6):  c.jump = 1'b1;
            OP_WIDTH'(7):  c.cv = 9'b1_0_0_0_1_0_0_1_0;
            OP_WIDTH'(8):  c.cv = 9'b1_1_0_0_1_0_0_0_1;
            OP_WIDTH'(15): c.stop = 1'b1;
            default:       c = '0;
        endcase
        return c;
    endfunction

    logic [INSTR_WIDTH-1:0] fifo_instr_q [BUF_DEPTH];
    logic [ADDR_WIDTH-1:0]  fifo_pc_q    [BUF_DEPTH];
    logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic                   halted_q, halted_d;
    logic                   out_vld_q, out_vld_d;
    logic [ADDR_WIDTH-1:0]  pc_q, pc_d;
    logic [REG_WIDTH-1:0]   rs_q, rs_d, rt_q, rt_d, rd_q, rd_d;
    logic [IMM_WIDTH-1:0]   imm_q, imm_d;
    logic [8:0]             cv_q, cv_d;

    logic [INSTR_WIDTH-1:0] head_instr;
    logic [REG_WIDTH-1:0]   head_rs, head_rt, head_rd, dst;
    logic [IMM_WIDTH-1:0]   head_imm;
    ctr_t                   head_ctr;
    logic                   head_vld, in_rdy, push, adv, hz, issue, pop;

    assign head_instr = fifo_instr_q[rd_ptr_q];
    assign head_rs    = head_instr[INSTR_WIDTH-OP_WIDTH-1 -: REG_WIDTH];
    assign head_rt    = head_instr[INSTR_WIDTH-OP_WIDTH-REG_WIDTH-1 -: REG_WIDTH];
    assign head_rd    = head_instr[REG_WIDTH-1:0];
    assign head_imm   = head_instr[IMM_WIDTH-1:0];
    assign head_ctr   = ctr_decode(head_instr[INSTR_WIDTH-1 -: OP_WIDTH]);
    assign head_vld   = (count_q != '0);

    // Ready looks only at registered state, so a full FIFO refuses even while popping.
    assign in_rdy = (count_q < CNT_W'(BUF_DEPTH)) && !halted_q;
    assign push   = bus.in_valid_i && in_rdy && !bus.flush_i;
    assign adv    = !out_vld_q || bus.out_ready_i;
    assign dst    = cv_q[CV_REGDST] ? rd_q : rt_q;
    assign hz     = out_vld_q && cv_q[CV_MEMREAD] && ((dst == head_rs) || (dst == head_rt));
    assign issue  = adv && head_vld && !hz && !halted_q;
    assign pop    = issue && !bus.flush_i;

    always_comb begin
        rd_ptr_d  = rd_ptr_q;
        wr_ptr_d  = wr_ptr_q;
        count_d   = count_q;
        halted_d  = halted_q;
        out_vld_d = out_vld_q;
        pc_d      = pc_q;
        rs_d      = rs_q;
        rt_d      = rt_q;
        rd_d      = rd_q;
        imm_d     = imm_q;
        cv_d      = cv_q;
        if (bus.flush_i || (adv && !issue)) begin
            out_vld_d = 1'b0;
            pc_d      = '0;
            rs_d      = '0;
            rt_d      = '0;
            rd_d      = '0;
            imm_d     = '0;
            cv_d      = '0;
        end else if (issue) begin
            out_vld_d = 1'b1;
            pc_d      = fifo_pc_q[rd_ptr_q];
            rs_d      = head_rs;
            rt_d      = head_rt;
            rd_d      = head_rd;
            imm_d     = head_imm;
            cv_d      = head_ctr.cv;
            if (head_ctr.stop) halted_d = 1'b1;
        end
        if (bus.flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
            halted_d = 1'b0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_instr_q[wr_ptr_q] <= bus.instr_i;
            fifo_pc_q[wr_ptr_q]    <= bus.pc_i;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            count_q   <= '0;
            halted_q  <= 1'b0;
            out_vld_q <= 1'b0;
            pc_q      <= '0;
            rs_q      <= '0;
            rt_q      <= '0;
            rd_q      <= '0;
            imm_q     <= '0;
            cv_q      <= '0;
        end else begin
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            count_q   <= count_d;
            halted_q  <= halted_d;
            out_vld_q <= out_vld_d;
            pc_q      <= pc_d;
            rs_q      <= rs_d;
            rt_q      <= rt_d;
            rd_q      <= rd_d;
            imm_q     <= imm_d;
            cv_q      <= cv_d;
        end
    end

    assign bus.in_ready_o  = in_rdy;
    assign bus.rf_r1_o     = head_rs;
    assign bus.rf_r2_o     = head_rt;
    assign bus.jump_o      = head_vld && head_ctr.jump;
    assign bus.jump_addr_o = head_imm;
    assign bus.halted_o    = halted_q;
    assign bus.out_valid_o = out_vld_q;
    assign bus.pc_o        = pc_q;
    assign bus.rs_o        = rs_q;
    assign bus.rt_o        = rt_q;
    assign bus.rd_o        = rd_q;
    assign bus.imm_o       = imm_q;
    assign bus.cv_o        = cv_q;

`ifdef ID_PERF_CNT_EN
    logic [15:0] bubble_cnt_q, full_cnt_q;

    // Counters survive flush; only reset clears them.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bubble_cnt_q <= '0;
            full_cnt_q   <= '0;
        end else begin
            if (adv && head_vld && !issue && !bus.flush_i) bubble_cnt_q <= bubble_cnt_q + 16'd1;
            if (bus.in_valid_i && !in_rdy)                 full_cnt_q   <= full_cnt_q + 16'd1;
        end
    end

    assign bus.bubble_cnt_o = bubble_cnt_q;
    assign bus.full_cnt_o   = full_cnt_q;
`endif
endmodule

// File: tb/tb_id_stage_hs.sv
// Bench for id_stage_hs: directed scenarios then random traffic, compared against a queue-based model.
`timescale 1ns/1ps
module tb_id_stage_hs;
    localparam int DEPTH = 2;
    localparam logic [8:0] RW = 9'h100, ALU = 9'h080, BR = 9'h040, MR = 9'h020, RDST = 9'h010;
    localparam logic [8:0] MW = 9'h008, M2R = 9'h004, MOV = 9'h002, FP = 9'h001;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    id_stage_hs_if #(.INSTR_WIDTH(16), .ADDR_WIDTH(8), .REG_WIDTH(4), .IMM_WIDTH(8)) bus ();

    id_stage_hs #(
        .INSTR_WIDTH(16), .ADDR_WIDTH(8), .OP_WIDTH(4), .REG_WIDTH(4), .IMM_WIDTH(8), .BUF_DEPTH(DEPTH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int checks = 0;
    int failures = 0;

    logic [15:0] q_i[$];
    logic [7:0]  q_p[$];
    logic        m_ov, m_halted;
    logic [7:0]  m_pc, m_imm;
    logic [3:0]  m_rs, m_rt, m_rd;
    logic [8:0]  m_cv;
`ifdef ID_PERF_CNT_EN
    logic [15:0] m_bub, m_full;
`endif

    // {stop, jump, cv}
    function automatic logic [10:0] ref_ctr(input logic [3:0] op);
        case (op)
            4'd1:    return {2'b00, RW | ALU | RDST};
            4'd2:    return {2'b00, RW | ALU};
            4'd3:    return {2'b00, RW | MR | M2R};
            4'd4:    return {2'b00, MW};
            4'd5:    return {2'b00, ALU | BR};
            4'd6:    return {2'b01, 9'h000};
            4'd7:    return {2'b00, RW | RDST | MOV};
            4'd8:    return {2'b00, RW | ALU | RDST | FP};
            4'd15:   return {2'b10, 9'h000};
            default: return 11'h000;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_bubble();
        m_ov = 1'b0; m_pc = '0; m_rs = '0; m_rt = '0; m_rd = '0; m_imm = '0; m_cv = '0;
    endtask

    task automatic model_reset();
        q_i.delete(); q_p.delete();
        model_bubble();
        m_halted = 1'b0;
`ifdef ID_PERF_CNT_EN
        m_bub = '0; m_full = '0;
`endif
    endtask

    task automatic check_regs();
        chk("out_valid", 32'(bus.out_valid_o), 32'(m_ov));
        chk("pc_o", 32'(bus.pc_o), 32'(m_pc));
        chk("rs_o", 32'(bus.rs_o), 32'(m_rs));
        chk("rt_o", 32'(bus.rt_o), 32'(m_rt));
        chk("rd_o", 32'(bus.rd_o), 32'(m_rd));
        chk("imm_o", 32'(bus.imm_o), 32'(m_imm));
        chk("cv_o", 32'(bus.cv_o), 32'(m_cv));
        chk("halted", 32'(bus.halted_o), 32'(m_halted));
`ifdef ID_PERF_CNT_EN
        chk("bubble_cnt", 32'(bus.bubble_cnt_o), 32'(m_bub));
        chk("full_cnt", 32'(bus.full_cnt_o), 32'(m_full));
`endif
    endtask

    // One clock: drive, check head-side outputs, advance model on the edge, check ID/EX.
    task automatic cycle(input logic iv, input logic [15:0] ins, input logic [7:0] pc,
                         input logic ordy, input logic fl);
        logic [15:0] h;
        logic [10:0] c;
        logic        ready, head_v, adv, hz;
        logic [3:0]  dst;
        bus.in_valid_i  = iv;
        bus.instr_i     = ins;
        bus.pc_i        = pc;
        bus.out_ready_i = ordy;
        bus.flush_i     = fl;
        #1;
        ready  = (q_i.size() < DEPTH) && !m_halted;
        head_v = (q_i.size() != 0);
        h      = head_v ? q_i[0] : 16'h0000;
        c      = ref_ctr(h[15:12]);
        chk("in_ready", 32'(bus.in_ready_o), 32'(ready));
        chk("jump_o", 32'(bus.jump_o), 32'(head_v && c[9]));
        if (head_v) begin
            chk("rf_r1", 32'(bus.rf_r1_o), 32'(h[11:8]));
            chk("rf_r2", 32'(bus.rf_r2_o), 32'(h[7:4]));
            chk("jump_addr", 32'(bus.jump_addr_o), 32'(h[7:0]));
        end
        @(posedge clk);
        adv = !m_ov || ordy;
        dst = m_cv[4] ? m_rd : m_rt;
        hz  = m_ov && m_cv[5] && head_v && ((dst == h[11:8]) || (dst == h[7:4]));
`ifdef ID_PERF_CNT_EN
        if (iv && !ready) m_full++;
        if (!fl && adv && head_v && (hz || m_halted)) m_bub++;
`endif
        if (fl) begin
            q_i.delete(); q_p.delete();
            model_bubble();
            m_halted = 1'b0;
        end else begin
            if (adv) begin
                if (head_v && !hz && !m_halted) begin
                    m_ov = 1'b1; m_pc = q_p[0];
                    m_rs = h[11:8]; m_rt = h[7:4]; m_rd = h[3:0]; m_imm = h[7:0];
                    m_cv = c[8:0];
                    if (c[10]) m_halted = 1'b1;
                    void'(q_i.pop_front()); void'(q_p.pop_front());
                end else begin
                    model_bubble();
                end
            end
            if (iv && ready) begin
                q_i.push_back(ins); q_p.push_back(pc);
            end
        end
        #1;
        check_regs();
        @(negedge clk);
    endtask

    task automatic idle(input logic ordy, input int n);
        for (int k = 0; k < n; k++) cycle(1'b0, 16'h0000, 8'h00, ordy, 1'b0);
    endtask

    initial begin
        logic [3:0] op, r1, r2, r3;
        int ops[10];
        ops = '{0, 1, 2, 3, 3, 4, 5, 6, 7, 8};
        rst = 1'b1;
        bus.in_valid_i = 1'b0; bus.instr_i = '0; bus.pc_i = '0; bus.flush_i = 1'b0; bus.out_ready_i = 1'b0;
        #2 rst = 1'b0;
        model_reset();
        #10;
        check_regs();
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst_in_ready", 32'(bus.in_ready_o), 32'd1);

        // Basic issue: two edges from push to ID/EX.
        cycle(1'b1, 16'h1234, 8'h05, 1'b1, 1'b0);
        idle(1'b1, 1);
        chk("t1_valid", 32'(bus.out_valid_o), 32'd1);
        chk("t1_pc", 32'(bus.pc_o), 32'h05);
        chk("t1_rs", 32'(bus.rs_o), 32'd2);
        chk("t1_rt", 32'(bus.rt_o), 32'd3);
        chk("t1_rd", 32'(bus.rd_o), 32'd4);
        chk("t1_imm", 32'(bus.imm_o), 32'h34);
        chk("t1_cv", 32'(bus.cv_o), 32'h190);
        idle(1'b1, 1);

        // Backpressure: fill FIFO, full refuses even while popping, order preserved.
        cycle(1'b1, 16'h2101, 8'h10, 1'b0, 1'b0);
        cycle(1'b1, 16'h2202, 8'h11, 1'b0, 1'b0);
        cycle(1'b1, 16'h2303, 8'h12, 1'b0, 1'b0);
        chk("t2_full_ready", 32'(bus.in_ready_o), 32'd0);
        cycle(1'b1, 16'h2404, 8'h13, 1'b1, 1'b0);
        chk("t2_pc_b", 32'(bus.pc_o), 32'h11);
        idle(1'b1, 1);
        chk("t2_pc_c", 32'(bus.pc_o), 32'h12);
        idle(1'b1, 1);
        chk("t2_drained", 32'(bus.out_valid_o), 32'd0);

        // Load-use: one bubble, then none when follower is independent.
        cycle(1'b1, 16'h3050, 8'h20, 1'b1, 1'b0);
        cycle(1'b1, 16'h1512, 8'h21, 1'b1, 1'b0);
        idle(1'b1, 1);
        chk("t3_bubble", 32'(bus.out_valid_o), 32'd0);
        idle(1'b1, 1);
        chk("t3_after_valid", 32'(bus.out_valid_o), 32'd1);
        chk("t3_after_pc", 32'(bus.pc_o), 32'h21);
        idle(1'b1, 1);
        cycle(1'b1, 16'h3050, 8'h30, 1'b1, 1'b0);
        cycle(1'b1, 16'h1671, 8'h31, 1'b1, 1'b0);
        idle(1'b1, 1);
        chk("t3_nobubble_pc", 32'(bus.pc_o), 32'h31);
        chk("t3_nobubble_valid", 32'(bus.out_valid_o), 32'd1);
        idle(1'b1, 1);

        // Stop: sticky halt, followers withheld, flush releases.
        cycle(1'b1, 16'hF000, 8'h40, 1'b1, 1'b0);
        cycle(1'b1, 16'h1111, 8'h41, 1'b1, 1'b0);
        chk("t4_halted", 32'(bus.halted_o), 32'd1);
        chk("t4_stop_pc", 32'(bus.pc_o), 32'h40);
        cycle(1'b1, 16'h1222, 8'h42, 1'b1, 1'b0);
        idle(1'b1, 3);
        chk("t4_no_issue", 32'(bus.out_valid_o), 32'd0);
        cycle(1'b0, 16'h0000, 8'h00, 1'b1, 1'b1);
        chk("t4_flush_halt", 32'(bus.halted_o), 32'd0);
        chk("t4_flush_ready", 32'(bus.in_ready_o), 32'd1);
        idle(1'b1, 2);

        // Jump visible at the FIFO head.
        cycle(1'b1, 16'h60AB, 8'h50, 1'b0, 1'b0);
        chk("t5_jump", 32'(bus.jump_o), 32'd1);
        chk("t5_jump_addr", 32'(bus.jump_addr_o), 32'hAB);
        idle(1'b1, 2);

        // Flush with a simultaneous push: both a full and a part-full FIFO.
        cycle(1'b1, 16'h1301, 8'h60, 1'b0, 1'b0);
        cycle(1'b1, 16'h1302, 8'h61, 1'b0, 1'b0);
        cycle(1'b1, 16'h1303, 8'h62, 1'b0, 1'b0);
        cycle(1'b1, 16'h1304, 8'h63, 1'b0, 1'b1);
        chk("t6_flush_valid", 32'(bus.out_valid_o), 32'd0);
        chk("t6_flush_cv", 32'(bus.cv_o), 32'd0);
        chk("t6_flush_jump", 32'(bus.jump_o), 32'd0);
        cycle(1'b1, 16'h1401, 8'h70, 1'b0, 1'b0);
        cycle(1'b1, 16'h1402, 8'h71, 1'b0, 1'b0);
        cycle(1'b1, 16'h1403, 8'h72, 1'b0, 1'b1);
        idle(1'b1, 2);
        chk("t6_dropped", 32'(bus.out_valid_o), 32'd0);

        // Asynchronous reset mid-transfer.
        cycle(1'b1, 16'h1501, 8'h80, 1'b0, 1'b0);
        cycle(1'b1, 16'h1502, 8'h81, 1'b0, 1'b0);
        cycle(1'b1, 16'h1503, 8'h82, 1'b0, 1'b0);
        bus.in_valid_i = 1'b0;
        #2 rst = 1'b0;
        #1;
        model_reset();
        check_regs();
        chk("t7_jump", 32'(bus.jump_o), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("t7_ready", 32'(bus.in_ready_o), 32'd1);

        // Random traffic with small register indices to provoke hazards.
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 99) < 3) op = 4'd15;
            else op = 4'(ops[$urandom_range(0, 9)]);
            r1 = 4'($urandom_range(0, 3));
            r2 = 4'($urandom_range(0, 3));
            r3 = 4'($urandom_range(0, 3));
            cycle(($urandom_range(0, 3) != 0), {op, r1, r2, r3}, 8'($urandom_range(0, 255)),
                  ($urandom_range(0, 2) != 0), ($urandom_range(0, 39) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
